serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 5 +
 rtl/serial_adder_full_adder_cell.sv | 23 ++
 rtl/serial_adder.sv | 71 +++++++
 tb/tb_serial_adder.sv | 126 ++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for the serial adder
package serial_adder_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// serial_adder_full_adder_cell: half-adder cell and the one-bit full adder built from two of them
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic s0, c0, c1;
  half_adder u_ha0 (.a(a),  .b(b),   .sum(s0),  .carry(c0));
  half_adder u_ha1 (.a(s0), .b(cin), .sum(sum), .carry(c1));
  assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder with start/done handshake
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  state_t state, nstate;
  logic [WIDTH-1:0] sa, sb, ps, ps_next;
  logic [CW-1:0] cnt;
  logic c, s, co, last;
  full_adder_cell u_fa (.a(sa[0]), .b(sb[0]), .cin(c), .sum(s), .cout(co));
  assign last    = cnt == CW'(WIDTH - 1);
  assign ps_next = (ps >> 1) | (WIDTH'(s) << (WIDTH - 1));
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end
  // next-state: illegal encoding falls back to IDLE
  always_comb begin
    nstate = IDLE;
    case (state)
      IDLE:    nstate = start ? SHIFT : IDLE;
      SHIFT:   nstate = last ? DONE : SHIFT;
      default: nstate = IDLE;
    endcase
  end
  // handshake outputs decoded from state
  always_comb begin
    busy = state == SHIFT || state == DONE;
    done = state == DONE;
  end
  // operand capture, per-bit shifting and result publication on the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa        <= '0;
      sb        <= '0;
      ps        <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else if (state == IDLE && start) begin
      sa  <= a;
      sb  <= b;
      c   <= 1'b0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      c   <= co;
      ps  <= ps_next;
      cnt <= last ? cnt : cnt + CW'(1);
      if (last) begin
        sum       <= ps_next;
        carry_out <= co;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder at WIDTH=8 and WIDTH=1
module tb_serial_adder;
  logic clk = 0, rst_n = 0;
  logic start8 = 0, start1 = 0;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic a1 = 0, b1 = 0, sum1;
  logic busy8, done8, co8, busy1, done1, co1;
  int checks = 0, errors = 0;

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .carry_out(co1));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one WIDTH=8 operation; optionally fires a second start while the first is in flight
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input bit inj, input string tag);
    int n, nb, nd;
    logic [8:0] e;
    e = {1'b0, x} + {1'b0, y};
    a8 = x; b8 = y; start8 = 1;
    step();
    start8 = 0;
    chk({tag, "_busy_rise"}, 64'(busy8), 64'd1);
    n = 0; nb = 1;
    while (!done8 && n < 40) begin
      if (inj && n == 2) begin a8 = 8'hFF; b8 = 8'hFF; start8 = 1; end
      else start8 = 0;
      step();
      n++;
      nb += int'(busy8);
    end
    start8 = 0;
    chk({tag, "_latency"}, 64'(n), 64'd8);
    chk({tag, "_busy_cycles"}, 64'(nb), 64'd9);
    chk({tag, "_result"}, 64'({co8, sum8}), 64'(e));
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      nd += int'(done8);
      if (i == 0) chk({tag, "_busy_fall"}, 64'(busy8), 64'd0);
    end
    chk({tag, "_extra_done"}, 64'(nd), 64'd0);
    chk({tag, "_hold"}, 64'({co8, sum8}), 64'(e));
  endtask

  initial begin
    int n, nd;
    logic [8:0] e8;
    logic [1:0] e1;
    step(); step();
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_result", 64'({co8, sum8}), 64'd0);
    chk("rst_w1", 64'({busy1, done1, co1, sum1}), 64'd0);
    rst_n = 1;
    nd = 0;
    for (int i = 0; i < 15; i++) begin step(); nd += int'(done8 | busy8); end
    chk("idle_quiet", 64'(nd), 64'd0);
    chk("idle_result", 64'({co8, sum8}), 64'd0);

    op8(8'h01, 8'h01, 0, "basic");
    op8(8'hFF, 8'h01, 0, "ripple");
    op8(8'hA5, 8'h5A, 0, "alt");
    op8(8'h10, 8'h20, 1, "start_busy");

    // reset during an operation
    a8 = 8'h80; b8 = 8'h80; start8 = 1;
    step();
    start8 = 0;
    step(); step(); step();
    rst_n = 0;
    #1;
    chk("abort_result", 64'({co8, sum8}), 64'd0);
    chk("abort_busy", 64'(busy8), 64'd0);
    step();
    rst_n = 1;
    nd = 0;
    for (int i = 0; i < 14; i++) begin step(); nd += int'(done8); end
    chk("abort_no_done", 64'(nd), 64'd0);
    op8(8'h80, 8'h80, 0, "after_abort");

    // random, start held high, WIDTH=8
    a8 = 8'($urandom); b8 = 8'($urandom); start8 = 1;
    for (int i = 0; i < 1000; i++) begin
      e8 = {1'b0, a8} + {1'b0, b8};
      n = 0;
      do begin step(); n++; end while (!done8 && n < 40);
      chk("rand8_result", 64'({co8, sum8}), 64'(e8));
      if (i > 0) chk("rand8_spacing", 64'(n), 64'd10);
      a8 = 8'($urandom); b8 = 8'($urandom);
    end
    start8 = 0;

    // random, start held high, WIDTH=1
    a1 = 1'($urandom); b1 = 1'($urandom); start1 = 1;
    for (int i = 0; i < 1000; i++) begin
      e1 = {1'b0, a1} + {1'b0, b1};
      n = 0;
      do begin step(); n++; end while (!done1 && n < 20);
      chk("rand1_result", 64'({co1, sum1}), 64'(e1));
      chk("rand1_spacing", 64'(n), (i > 0) ? 64'd3 : 64'd2);
      a1 = 1'($urandom); b1 = 1'($urandom);
    end
    start1 = 0;
    step(); step();
    chk("w1_idle", 64'({busy1, done1}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
